// File: rtl/cyclic_encode_sequencer.sv
// Serial systematic cyclic (7,4) encoder, g(x) = x^3 + x + 1.
// A message is accepted in IDLE. Its four data bits are emitted MSB first,
// then the three parity bits held in the LFSR. An optional idle gap follows
// each codeword. All codeword output uses a valid/ready handshake.
module cyclic_encode_sequencer #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       msg_valid,
    input  logic [3:0] msg_data,
    output logic       msg_ready,
    output logic       cw_valid,
    input  logic       cw_ready,
    output logic       cw_bit,
    output logic       cw_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StMsg,
        StPar,
        StGap
    } state_t;

    // Terminal value of the gap counter. It is unused when there is no gap.
    localparam logic [3:0] GapLast = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] msg_q, msg_d;
    logic [2:0] lfsr_q, lfsr_d;   // {r2, r1, r0}
    logic [2:0] cnt_q, cnt_d;     // codeword bit index 0..6
    logic [3:0] gap_q, gap_d;
    logic       cw_fire;
    logic       fb;

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            msg_q   <= 4'd0;
            lfsr_q  <= 3'd0;
            cnt_q   <= 3'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        msg_ready = 1'b0;
        cw_valid  = 1'b0;
        cw_bit    = 1'b0;
        cw_last   = 1'b0;
        fb        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst so that no output is high while reset is held
                msg_ready = rst;
                if (msg_valid) begin
                    msg_d   = msg_data;
                    lfsr_d  = 3'd0;
                    cnt_d   = 3'd0;
                    state_d = StMsg;
                end
            end
            StMsg: begin
                cw_valid = 1'b1;
                // Bit k of the codeword is m[3-k], and 3-k equals ~k on 2 bits
                cw_bit   = msg_q[~cnt_q[1:0]];
                if (cw_ready) begin
                    fb     = cw_bit ^ lfsr_q[2];
                    lfsr_d = {lfsr_q[1], lfsr_q[0] ^ fb, fb};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d = StPar;
                    end
                end
            end
            StPar: begin
                cw_valid = 1'b1;
                cw_bit   = lfsr_q[2];
                cw_last  = (cnt_q == 3'd6);
                if (cw_ready) begin
                    lfsr_d = {lfsr_q[1:0], 1'b0};
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over any handshake in the same cycle
        if (flush) begin
            state_d = StIdle;
            msg_d   = 4'd0;
            lfsr_d  = 3'd0;
            cnt_d   = 3'd0;
            gap_d   = 4'd0;
        end
    end

    assign cw_fire = cw_valid & cw_ready & ~flush;

    // Status output
    always_comb begin
        busy = (state_q != StIdle);
    end

    // cw_fire marks a completed codeword-bit handshake; this block does not use it
    logic unused_fire;
    assign unused_fire = cw_fire;

endmodule

// File: tb/tb_cyclic_encode_sequencer.sv
// Randomised and directed bench for cyclic_encode_sequencer. A polynomial
// reference model predicts the outputs. A negedge checker compares every cycle.
module tb_cyclic_encode_sequencer;

    localparam int unsigned GAP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       msg_valid = 1'b0;
    logic [3:0] msg_data = 4'd0;
    logic       cw_ready = 1'b0;
    logic       msg_ready, cw_valid, cw_bit, cw_last, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the pending codeword bits plus the remaining gap cycles
    logic m_bits[$];
    int   m_gap = 0;
    // The bits the DUT actually handed over, used by the directed tests
    logic log_q[$];

    cyclic_encode_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_bit    (cw_bit),
        .cw_last   (cw_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t: timed out", name, $time);
    endtask

    // c(x) = m(x)x^3 + (m(x)x^3 mod g(x)), by long division over GF(2)
    function automatic logic [6:0] encode(input logic [3:0] m);
        logic [6:0] v;
        v = {m, 3'b000};
        for (int i = 6; i >= 3; i--) begin
            if (v[i]) v = v ^ (7'b0001011 << (i - 3));
        end
        return {m, v[2:0]};
    endfunction

    function automatic logic [6:0] log_word(input int first);
        logic [6:0] w;
        w = 7'd0;
        for (int i = 0; i < 7; i++) begin
            if (first + i < log_q.size()) w[6 - i] = log_q[first + i];
        end
        return w;
    endfunction

    // Per-cycle compare against the model, then advance the model across the edge
    always @(negedge clk) begin
        logic e_rdy, e_val, e_bit, e_last, e_busy;
        logic [6:0] cw;
        e_rdy = 0; e_val = 0; e_bit = 0; e_last = 0; e_busy = 0;
        if (rst) begin
            if (m_bits.size() > 0) begin
                e_val  = 1;
                e_bit  = m_bits[0];
                e_last = (m_bits.size() == 1);
                e_busy = 1;
            end else if (m_gap > 0) begin
                e_busy = 1;
            end else begin
                e_rdy = 1;
            end
        end
        check("msg_ready", {7'd0, msg_ready}, {7'd0, e_rdy});
        check("cw_valid", {7'd0, cw_valid}, {7'd0, e_val});
        check("cw_bit", {7'd0, cw_bit}, {7'd0, e_bit});
        check("cw_last", {7'd0, cw_last}, {7'd0, e_last});
        check("busy", {7'd0, busy}, {7'd0, e_busy});

        if (!rst || flush) begin
            m_bits.delete();
            m_gap = 0;
        end else if (m_bits.size() > 0) begin
            if (cw_ready) begin
                log_q.push_back(cw_bit);
                void'(m_bits.pop_front());
                if (m_bits.size() == 0) m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (msg_valid) begin
            cw = encode(msg_data);
            for (int i = 6; i >= 0; i--) m_bits.push_back(cw[i]);
        end
    end

    task automatic send_msg(input logic [3:0] m);
        int k;
        msg_valid = 1'b1;
        msg_data  = m;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (msg_ready) break;
        end
        if (k == 50) timeout("send_msg");
        @(posedge clk);
        #1 msg_valid = 1'b0;
    endtask

    // Returns just after the edge at which the n-th logged handshake completed
    task automatic wait_bits(input int n);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (log_q.size() >= n) break;
        end
        if (k == 200) timeout("wait_bits");
        #1;
    endtask

    task automatic run_msg(input logic [3:0] m, input logic [6:0] exp, input string name);
        log_q.delete();
        send_msg(m);
        wait_bits(7);
        check(name, {1'b0, log_word(0)}, {1'b0, exp});
    endtask

    initial begin
        int gcnt;
        logic pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Checks the model's encoder against hand-computed codewords
        check("enc_1000", {1'b0, encode(4'b1000)}, 8'b0100_0101);
        check("enc_0001", {1'b0, encode(4'b0001)}, 8'b0000_1011);
        check("enc_1111", {1'b0, encode(4'b1111)}, 8'b0111_1111);
        check("enc_0000", {1'b0, encode(4'b0000)}, 8'b0000_0000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {7'd0, msg_ready}, 8'd1);
        @(posedge clk);
        #1;

        cw_ready = 1'b1;
        run_msg(4'b1000, 7'b1000101, "cw_1000");
        run_msg(4'b0001, 7'b0001011, "cw_0001");
        run_msg(4'b1111, 7'b1111111, "cw_1111");
        run_msg(4'b0000, 7'b0000000, "cw_0000");

        // Stalls: cw_ready follows 1,0,0,1,...
        log_q.delete();
        send_msg(4'b1000);
        for (int i = 0; i < 60 && log_q.size() < 7; i++) begin
            cw_ready = pat[i % 4];
            @(posedge clk);
            #1;
        end
        check("stall_1000", {1'b0, log_word(0)}, 8'b0100_0101);
        cw_ready = 1'b1;
        repeat (GAP + 1) @(posedge clk);
        #1;

        // Flush during the 5th bit, then a clean codeword follows
        log_q.delete();
        send_msg(4'b1000);
        wait_bits(4);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_count", 8'(log_q.size()), 8'd4);
        check("flush_idle", {7'd0, msg_ready}, 8'd1);
        run_msg(4'b0001, 7'b0001011, "after_flush");
        repeat (10) @(posedge clk);
        #1 check("after_flush_len", 8'(log_q.size()), 8'd7);

        // Back-to-back with msg_valid held high; measure the gap
        log_q.delete();
        msg_valid = 1'b1;
        msg_data  = 4'b1010;
        wait_bits(7);
        msg_data = 4'b0110;
        gcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (msg_ready) break;
            gcnt++;
        end
        check("gap_len", 8'(gcnt), 8'(GAP));
        wait_bits(14);
        msg_valid = 1'b0;
        check("b2b_first", {1'b0, log_word(0)}, {1'b0, 7'b1010011});
        check("b2b_second", {1'b0, log_word(7)}, {1'b0, 7'b0110001});
        repeat (GAP + 1) @(posedge clk);
        #1;

        // Reset during the parity phase
        log_q.delete();
        send_msg(4'b1111);
        wait_bits(5);
        rst = 1'b0;
        #1;
        check("rst_outputs", {3'd0, msg_ready, cw_valid, cw_bit, cw_last, busy}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {7'd0, msg_ready}, 8'd1);
        repeat (10) @(posedge clk);
        #1 check("rst_no_residue", 8'(log_q.size()), 8'd5);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            msg_valid = 1'($urandom_range(0, 1));
            msg_data  = 4'($urandom);
            cw_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush = 1'b0;
        msg_valid = 1'b0;
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cyclic_encode_sequencer.md
CYCLIC_ENCODE_SEQUENCER -- requirements
Module: cyclic_encode_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 0: idle cycles inserted after each codeword before msg_ready reasserts; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately, release is synchronous to clk.
REQ-004 flush  input  1  synchronous abort; drops the codeword in progress.
REQ-005 msg_valid  input  1  msg_data holds a message.
REQ-006 msg_data  input  4  message m3..m0; m3 is the highest-order coefficient.
REQ-007 msg_ready  output  1  block accepts a message this cycle.
REQ-008 cw_valid  output  1  cw_bit holds a codeword bit.
REQ-009 cw_ready  input  1  downstream consumes cw_bit this cycle.
REQ-010 cw_bit  output  1  serial systematic (7,4) codeword bit.
REQ-011 cw_last  output  1  high with the 7th (final parity) bit.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Code SHALL be cyclic (7,4), g(x)=x^3+x+1, systematic: c(x)=m(x)*x^3 + (m(x)*x^3 mod g(x)).
REQ-014 Internal parity LFSR r2,r1,r0 SHALL update per consumed message bit b: fb=b^r2; r0<=fb; r1<=r0^fb; r2<=r1.
REQ-015 States SHALL be IDLE, MSG, PAR and GAP.
REQ-016 IDLE: msg_ready=1, cw_valid=0; msg_valid&msg_ready latches msg_data, clears the LFSR and bit counter, then -> MSG.
REQ-017 MSG: cw_valid=1, cw_bit=latched m[3-k] for k=0..3; each cw_valid&cw_ready advances k and clocks the LFSR with that bit; the 4th handshake -> PAR.
REQ-018 PAR: cw_valid=1, cw_bit=r2; each handshake shifts r2<=r1, r1<=r0, r0<=0 (no feedback); the 3rd handshake, with cw_last=1, -> GAP if GAP_CYCLES>0, else IDLE.
REQ-019 GAP: cw_valid=0, msg_ready=0; counts GAP_CYCLES cycles, then -> IDLE.
REQ-020 Latency: message accepted at edge T SHALL give cw_valid=1 with bit m3 in cycle T+1; 7 bits SHALL complete in 7 cycles with cw_ready held high.
REQ-021 cw_bit and cw_last SHALL stay stable while cw_valid=1 and cw_ready=0; the LFSR and counter SHALL not advance.
REQ-022 msg_ready SHALL be 0 outside IDLE; msg_valid outside IDLE SHALL be ignored and not buffered.
REQ-023 flush=1 SHALL force IDLE next cycle and clear the LFSR, counters and latched message, with no handshake completing that cycle; flush takes priority over msg_valid and cw_ready.
REQ-024 cw_last SHALL be 0 except on the 7th bit; cw_bit SHALL be 0 when cw_valid=0.
REQ-025 The bit counter SHALL be 3 bits, count 0..6 and never wrap past 6.

Reset
REQ-026 While rst=0: state=IDLE, LFSR=000, counters=0, latched message=0000; msg_ready=0, cw_valid=0, cw_bit=0, cw_last=0, busy=0.
REQ-027 msg_ready SHALL assert in the first cycle after rst is released.
REQ-028 Reset mid-codeword SHALL discard the partial codeword; no further bits of it are emitted.

Verification
REQ-029 msg 1000, cw_ready=1 -> bits 1,0,0,0,1,0,1 on cycles T+1..T+7; cw_last only on the 7th bit.
REQ-030 msg 0001 -> 0,0,0,1,0,1,1; msg 1111 -> 1,1,1,1,1,1,1; msg 0000 -> seven 0s.
REQ-031 msg 1000, cw_ready toggled 1,0,0,1,... -> cw_bit held across stalls; emitted sequence still 1000101.
REQ-032 flush asserted at the 5th bit of msg 1000 -> IDLE next cycle; a following msg 0001 yields exactly 0001011.
REQ-033 GAP_CYCLES=3, back-to-back msg_valid -> msg_ready low for 3 cycles after cw_last before the next accept; msg_valid during MSG/PAR ignored.
REQ-034 rst pulsed low during PAR -> all outputs 0 immediately; after release, IDLE with msg_ready=1 and no residual bits.
